// File: rtl/dmem_mmio.sv
// Data memory with memory-mapped LED, cycle counter and debug TX FIFO.
// Ports: clk, reset (async, active-high); CPU side MemWrite/ALUresult/WriteData -> ReadData;
//        led[7:0]; debug stream dbg_data/dbg_valid out, dbg_ready in.
module dmem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUresult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  led,
    output logic [7:0]  dbg_data,
    output logic        dbg_valid,
    input  logic        dbg_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // MMIO word addresses (byte address >> 2)
    localparam logic [29:0] LED_A = 30'h3FFF_C000;
    localparam logic [29:0] CYC_A = 30'h3FFF_C001;
    localparam logic [29:0] TX_A  = 30'h3FFF_C002;
    localparam logic [29:0] ST_A  = 30'h3FFF_C003;

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   cycles;
    logic          overflow;

    logic          is_ram, is_led, is_cyc, is_tx, is_st;
    logic [AW-1:0] idx;
    logic          full, empty, pop, push, tx_wr, ovf_set, ovf_clr;
    logic [3:0]    count4;
    logic [31:0]   status;
    logic          unused_bits;

    // Byte offset inside a word never matters.
    assign unused_bits = ^ALUresult[1:0];

    assign is_ram = (ALUresult[31:16] == 16'h0);
    assign is_led = (ALUresult[31:2] == LED_A);
    assign is_cyc = (ALUresult[31:2] == CYC_A);
    assign is_tx  = (ALUresult[31:2] == TX_A);
    assign is_st  = (ALUresult[31:2] == ST_A);
    assign idx    = ALUresult[2 +: AW];

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop     = !empty && dbg_ready;
    assign tx_wr   = MemWrite && is_tx;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign push    = tx_wr && (!full || pop);
    assign ovf_set = tx_wr && full && !pop;
    assign ovf_clr = MemWrite && is_st && WriteData[6];

    assign count4 = 4'(count);
    assign status = {25'h0, overflow, count4, empty, full};

    // FIFO storage is not reset; output is gated so reset shows zero.
    assign dbg_valid = !empty;
    assign dbg_data  = empty ? 8'h00 : fifo[rd_ptr];

    always_comb begin
        ReadData = 32'h0;
        unique case (1'b1)
            is_ram:  ReadData = ram[idx];
            is_led:  ReadData = {24'h0, led};
            is_cyc:  ReadData = cycles;
            is_st:   ReadData = status;
            default: ReadData = 32'h0;
        endcase
    end

    // RAM and FIFO slots hold no reset; writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (!reset && MemWrite && is_ram)
            ram[idx] <= WriteData;
        if (!reset && push)
            fifo[wr_ptr] <= WriteData[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led      <= 8'h0;
            cycles   <= 32'h0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (MemWrite && is_led)
                led <= WriteData[7:0];
            if (MemWrite && is_cyc)
                cycles <= 32'h0;
            else
                cycles <= cycles + 32'h1;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            // Set wins over a same-cycle clear.
            overflow <= (overflow && !ovf_clr) || ovf_set;
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized self-checking bench for dmem_mmio against a queue-based model.
// Directed scenarios first, then random traffic.
module tb_dmem_mmio;

    localparam int D = 4;
    localparam logic [31:0] LED_A = 32'hFFFF_0000;
    localparam logic [31:0] CYC_A = 32'hFFFF_0004;
    localparam logic [31:0] TX_A  = 32'hFFFF_0008;
    localparam logic [31:0] ST_A  = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUresult = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic [7:0]  led;
    logic [7:0]  dbg_data;
    logic        dbg_valid;
    logic        dbg_ready = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    logic [31:0] m_ram [64];
    bit          m_ok [64];
    logic [7:0]  m_led;
    logic [31:0] m_cyc;
    logic [7:0]  m_q [$];
    bit          m_ovf;

    dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(D)) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .ALUresult(ALUresult),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .led(led),
        .dbg_data(dbg_data),
        .dbg_valid(dbg_valid),
        .dbg_ready(dbg_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void model_reset();
        m_led = 8'h0;
        m_cyc = 32'h0;
        m_q.delete();
        m_ovf = 1'b0;
    endfunction

    function automatic logic [31:0] model_status();
        int n;
        n = m_q.size();
        return {25'h0, m_ovf, 4'(n), n == 0, n == D};
    endfunction

    function automatic void model_read(input logic [31:0] a,
                                       output logic [31:0] e,
                                       output bit known);
        logic [31:0] w;
        int i;
        w = a & ~32'h3;
        known = 1'b1;
        e = 32'h0;
        if (a[31:16] == 16'h0) begin
            i = int'((a >> 2) % 64);
            known = m_ok[i];
            e = m_ram[i];
        end else if (w == LED_A) e = {24'h0, m_led};
        else if (w == CYC_A) e = m_cyc;
        else if (w == ST_A) e = model_status();
    endfunction

    function automatic void model_clock(bit we, logic [31:0] a,
                                        logic [31:0] d, bit rdy);
        logic [31:0] w;
        bit do_pop, tx, was_full;
        int i;
        if (reset) begin
            model_reset();
            return;
        end
        w = a & ~32'h3;
        tx = we && (w == TX_A);
        was_full = (m_q.size() == D);
        do_pop = (m_q.size() != 0) && rdy;
        if (we && a[31:16] == 16'h0) begin
            i = int'((a >> 2) % 64);
            m_ram[i] = d;
            m_ok[i] = 1'b1;
        end
        if (we && w == LED_A) m_led = d[7:0];
        if (we && w == CYC_A) m_cyc = 32'h0;
        else m_cyc = m_cyc + 32'h1;
        if (we && w == ST_A && d[6]) m_ovf = 1'b0;
        if (tx && was_full && !do_pop) m_ovf = 1'b1;
        if (do_pop) void'(m_q.pop_front());
        if (tx && (!was_full || do_pop)) m_q.push_back(d[7:0]);
    endfunction

    // One clock: drive at negedge, check outputs, clock, update model.
    task automatic step(bit we, logic [31:0] a, logic [31:0] d, bit rdy);
        logic [31:0] e;
        bit known;
        MemWrite = we;
        ALUresult = a;
        WriteData = d;
        dbg_ready = rdy;
        #1;
        model_read(a, e, known);
        if (known) chk("rdata", ReadData, e);
        chk("led", {24'h0, led}, {24'h0, m_led});
        chk("valid", {31'h0, dbg_valid}, {31'h0, m_q.size() != 0});
        chk("dbg", {24'h0, dbg_data},
            {24'h0, (m_q.size() != 0) ? m_q[0] : 8'h0});
        @(posedge clk);
        model_clock(we, a, d, rdy);
        @(negedge clk);
    endtask

    task automatic peek(logic [31:0] a, output logic [31:0] r);
        MemWrite = 1'b0;
        ALUresult = a;
        #1;
        r = ReadData;
    endtask

    logic [31:0] r;
    logic [31:0] a;
    int k;

    initial begin
        for (int i = 0; i < 64; i++) m_ok[i] = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_led", {24'h0, led}, 32'h0);
        chk("rst_valid", {31'h0, dbg_valid}, 32'h0);
        peek(ST_A, r);
        chk("rst_status", r, 32'h2);
        reset = 1'b0;

        // Counter from reset release
        for (int i = 0; i < 10; i++) step(0, CYC_A, 0, 0);
        peek(CYC_A, r);
        chk("cyc10", r, 32'd10);
        step(1, CYC_A, 32'h1234, 0);
        peek(CYC_A, r);
        chk("cyc_clr", r, 32'h0);
        force dut.cycles = 32'hFFFF_FFFF;
        #1;
        release dut.cycles;
        m_cyc = 32'hFFFF_FFFF;
        step(0, CYC_A, 0, 0);
        peek(CYC_A, r);
        chk("cyc_wrap", r, 32'h0);

        // RAM aliasing
        step(1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        peek(32'h0000_0013, r);
        chk("ram_byte", r, 32'hDEAD_BEEF);
        peek(32'h0000_0110, r);
        chk("ram_alias", r, 32'hDEAD_BEEF);
        step(1, 32'h0001_0010, 32'h5555_5555, 0);
        peek(32'h0000_0010, r);
        chk("unmapped_wr", r, 32'hDEAD_BEEF);

        // FIFO fill past full
        for (int i = 0; i < 5; i++) step(1, TX_A, 32'h41 + i, 0);
        peek(ST_A, r);
        chk("fill_status", r, 32'h51);
        chk("fill_head", {24'h0, dbg_data}, 32'h41);
        peek(TX_A, r);
        chk("tx_read", r, 32'h0);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            dbg_ready = 1'b1;
            #1;
            chk("drain", {24'h0, dbg_data}, 32'h41 + i);
            step(0, ST_A, 0, 1);
        end
        chk("drained", {31'h0, dbg_valid}, 32'h0);
        step(1, ST_A, 32'h40, 0);
        peek(ST_A, r);
        chk("ovf_clr", r, 32'h2);

        // Full with simultaneous pop
        for (int i = 0; i < 4; i++) step(1, TX_A, 32'h60 + i, 0);
        step(1, TX_A, 32'h99, 1);
        peek(ST_A, r);
        chk("full_pop", r, 32'h11);
        step(0, ST_A, 0, 0);

        // Async reset between edges
        step(1, LED_A, 32'hA5, 0);
        chk("led_a5", {24'h0, led}, 32'hA5);
        MemWrite = 1'b1;
        ALUresult = LED_A;
        WriteData = 32'hFF;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_led", {24'h0, led}, 32'h0);
        chk("arst_valid", {31'h0, dbg_valid}, 32'h0);
        chk("arst_data", {24'h0, dbg_data}, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_wr_drop", {24'h0, led}, 32'h0);
        reset = 1'b0;
        step(0, CYC_A, 0, 0);
        peek(CYC_A, r);
        chk("cyc_resume", r, 32'h1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 6);
            case (k)
                0, 1: a = {16'h0, 16'($urandom)};
                2: a = LED_A | ($urandom & 3);
                3: a = CYC_A | ($urandom & 3);
                4: a = TX_A | ($urandom & 3);
                5: a = ST_A | ($urandom & 3);
                default: a = ($urandom & 1) ? 32'hFFFF_0010 : 32'h8001_2340;
            endcase
            step(($urandom_range(0, 2) != 0), a, $urandom,
                 ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 64, number of 32-bit data RAM words (power of 2, 16..1024).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, debug TX FIFO entries (power of 2, 2..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port MemWrite  input  1  write strobe from the CPU data port.
REQ-006 SHALL have port ALUresult  input  32  byte address from the CPU data port.
REQ-007 SHALL have port WriteData  input  32  store data from the CPU.
REQ-008 SHALL have port ReadData  output  32  load data returned to the CPU.
REQ-009 SHALL have port led  output  8  LED register contents.
REQ-010 SHALL have port dbg_data  output  8  head byte of the debug TX FIFO.
REQ-011 SHALL have port dbg_valid  output  1  FIFO non-empty; dbg_data is valid.
REQ-012 SHALL have port dbg_ready  input  1  downstream consumer accepts dbg_data.

Function
REQ-013 SHALL decode the address map: ALUresult[31:16]==0 -> RAM; 0xFFFF_0000 LED; 0xFFFF_0004 CYCLES; 0xFFFF_0008 TXDATA; 0xFFFF_000C STATUS; all others unmapped.
REQ-014 SHALL ignore ALUresult[1:0]; RAM word index = ALUresult[2 +: log2(RAM_WORDS)], upper in-range bits ignored (aliasing).
REQ-015 SHALL drive ReadData combinationally from the current address, with zero latency, for the single-cycle CPU.
REQ-016 SHALL perform writes on the rising clk edge when MemWrite=1; written data is visible on ReadData from the following cycle.
REQ-017 SHALL return RAM word on RAM reads; {24'b0,led} on LED; cycle counter on CYCLES; 0 on TXDATA reads; STATUS word on STATUS reads; 0 on unmapped reads.
REQ-018 SHALL ignore writes to unmapped addresses with no side effects.
REQ-019 SHALL load led <= WriteData[7:0] on an LED write.
REQ-020 SHALL increment the 32-bit cycle counter every cycle, wrapping 0xFFFF_FFFF -> 0; a CYCLES write SHALL load 0, overriding the increment.
REQ-021 SHALL push WriteData[7:0] into the FIFO on a TXDATA write if not full, or if full and a pop occurs the same cycle.
REQ-022 SHALL drop a TXDATA write when full with no same-cycle pop, and set the sticky overflow flag.
REQ-023 SHALL pop the head when dbg_valid && dbg_ready; dbg_data SHALL hold steady while dbg_valid=1 and dbg_ready=0.
REQ-024 SHALL have no empty-FIFO bypass: a push into an empty FIFO raises dbg_valid in the next cycle.
REQ-025 SHALL keep the FIFO count at 0..FIFO_DEPTH; simultaneous push+pop leaves the count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-026 SHALL format the STATUS word as bit0 full, bit1 empty, bits[5:2] count, bit6 overflow, other bits 0.
REQ-027 SHALL clear overflow on a STATUS write with WriteData[6]=1; other STATUS bits are read-only.
REQ-028 SHALL give a same-cycle overflow set and clear priority to set.

Reset
REQ-029 SHALL, on reset assertion, immediately set led=0, counter=0, FIFO empty (pointers and count 0), overflow=0, dbg_valid=0, dbg_data=0.
REQ-030 SHALL NOT reset RAM contents; RAM is undefined until written.
REQ-031 SHALL, on reset mid-operation, discard FIFO contents and any write in the same cycle.
REQ-032 SHALL resume counting from 0 on the first rising edge after reset deasserts.

Verification
REQ-033 SHALL test RAM access: write 0xDEADBEEF to 0x0000_0010, read 0x0000_0013 and 0x0000_0110 (RAM_WORDS=64) -> 0xDEADBEEF both.
REQ-034 SHALL test the counter: release reset, read CYCLES after 10 edges -> 10; write CYCLES -> next-cycle read 0; force counter 0xFFFF_FFFF -> next read 0.
REQ-035 SHALL test FIFO fill with dbg_ready=0: push 0x41..0x45 -> STATUS=0x0000_0051 (full, count 4, overflow); dbg_data=0x41.
REQ-036 SHALL test drain and clear: dbg_ready=1 for 4 cycles -> bytes 0x41,0x42,0x43,0x44 in order, then dbg_valid=0; write STATUS 0x40 -> STATUS=0x0000_0002.
REQ-037 SHALL test full with simultaneous pop: push while full and dbg_ready=1 -> byte accepted, count stays 4, overflow stays 0.
REQ-038 SHALL test async reset: assert reset between clock edges with led=0xA5 and FIFO non-empty -> led=0 and dbg_valid=0 before the next edge.
